// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender.
// Holds the extension mode codes and the skid buffer state encoding.
package imm_ext_pkg;

  localparam logic [2:0] MODE_SIGN   = 3'd0;
  localparam logic [2:0] MODE_ZERO   = 3'd1;
  localparam logic [2:0] MODE_UPPER  = 3'd2;
  localparam logic [2:0] MODE_BRANCH = 3'd3;
  localparam logic [2:0] MODE_SHAMT  = 3'd4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/imm_extend_stage_if.sv
// Handshake bundle for the immediate extender.
//   i_valid/o_ready/i_imm/i_mode : upstream beat into the extender
//   o_valid/i_ready/o_ext/o_mode_err : downstream beat out of the extender
// slave  : the extender side
// master : the environment driving the extender
interface imm_extend_stage_if #(
  parameter int NBITS   = 16,
  parameter int EXTBITS = 32
);
  logic               i_valid;
  logic               o_ready;
  logic [NBITS-1:0]   i_imm;
  logic [2:0]         i_mode;
  logic               o_valid;
  logic               i_ready;
  logic [EXTBITS-1:0] o_ext;
  logic               o_mode_err;

  modport slave (
    input  i_valid, i_imm, i_mode, i_ready,
    output o_ready, o_valid, o_ext, o_mode_err
  );

  modport master (
    output i_valid, i_imm, i_mode, i_ready,
    input  o_ready, o_valid, o_ext, o_mode_err
  );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extension mux.
//   i_imm  : raw NBITS immediate
//   i_mode : extension mode (codes from imm_ext_pkg)
//   o_ext  : EXTBITS extended value (0 for an illegal mode)
//   o_err  : high when i_mode is not a defined mode
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int NBITS     = 16,
  parameter int EXTBITS   = 32,
  parameter int SHAMTBITS = 5
) (
  input  logic [NBITS-1:0]   i_imm,
  input  logic [2:0]         i_mode,
  output logic [EXTBITS-1:0] o_ext,
  output logic               o_err
);

  logic [EXTBITS-1:0] sign_ext;

  // Sign extension: low bits copy the immediate, upper bits copy its MSB.
  for (genvar gi = 0; gi < EXTBITS; gi++) begin : g_sext
    if (gi < NBITS) begin : g_low
      assign sign_ext[gi] = i_imm[gi];
    end else begin : g_high
      assign sign_ext[gi] = i_imm[NBITS-1];
    end
  end

  always_comb begin
    o_ext = '0;
    o_err = 1'b0;
    case (i_mode)
      MODE_SIGN:   o_ext = sign_ext;
      MODE_ZERO:   o_ext = {{(EXTBITS-NBITS){1'b0}}, i_imm};
      MODE_UPPER:  o_ext = {i_imm, {(EXTBITS-NBITS){1'b0}}};
      // Word offset: the two bits shifted out of the top are discarded.
      MODE_BRANCH: o_ext = {sign_ext[EXTBITS-3:0], 2'b00};
      MODE_SHAMT:  o_ext = {{(EXTBITS-SHAMTBITS){1'b0}}, i_imm[SHAMTBITS-1:0]};
      default:     o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered multi-mode immediate extender with a 2-entry skid buffer.
//   i_clk, i_reset : clock and synchronous active-high reset
//   i_flush        : synchronous flush, drops everything held and any beat offered
//   bus            : input beat (i_valid/o_ready/i_imm/i_mode) and output beat
//                    (o_valid/i_ready/o_ext/o_mode_err)
// o_ready depends only on registered state, never on i_ready.
module imm_extend_stage
  import imm_ext_pkg::*;
#(
  parameter int NBITS     = 16,
  parameter int EXTBITS   = 32,
  parameter int SHAMTBITS = 5
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_flush,
  imm_extend_stage_if.slave   bus
);

  state_t             state_q, state_d;
  logic [EXTBITS-1:0] main_ext_q, main_ext_d;
  logic               main_err_q, main_err_d;
  logic [EXTBITS-1:0] skid_ext_q, skid_ext_d;
  logic               skid_err_q, skid_err_d;

  logic [EXTBITS-1:0] new_ext;
  logic               new_err;
  logic               in_fire;
  logic               out_fire;

  imm_ext_core #(
    .NBITS    (NBITS),
    .EXTBITS  (EXTBITS),
    .SHAMTBITS(SHAMTBITS)
  ) u_core (
    .i_imm (bus.i_imm),
    .i_mode(bus.i_mode),
    .o_ext (new_ext),
    .o_err (new_err)
  );

  assign in_fire  = bus.i_valid && (state_q != ST_TWO);
  assign out_fire = (state_q != ST_EMPTY) && bus.i_ready;

  always_comb begin
    state_d    = state_q;
    main_ext_d = main_ext_q;
    main_err_d = main_err_q;
    skid_ext_d = skid_ext_q;
    skid_err_d = skid_err_q;
    if (i_flush) begin
      state_d    = ST_EMPTY;
      main_ext_d = '0;
      main_err_d = 1'b0;
      skid_ext_d = '0;
      skid_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d    = ST_ONE;
            main_ext_d = new_ext;
            main_err_d = new_err;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ext_d = new_ext;
            main_err_d = new_err;
          end else if (in_fire) begin
            // Downstream stalled: park the new beat behind the held one.
            state_d    = ST_TWO;
            skid_ext_d = new_ext;
            skid_err_d = new_err;
          end else if (out_fire) begin
            // Clear so an idle output never shows a stale error flag.
            state_d    = ST_EMPTY;
            main_ext_d = '0;
            main_err_d = 1'b0;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d    = ST_ONE;
            main_ext_d = skid_ext_q;
            main_err_d = skid_err_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_EMPTY;
      main_ext_q <= '0;
      main_err_q <= 1'b0;
      skid_ext_q <= '0;
      skid_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_ext_q <= main_ext_d;
      main_err_q <= main_err_d;
      skid_ext_q <= skid_ext_d;
      skid_err_q <= skid_err_d;
    end
  end

  assign bus.o_valid    = (state_q != ST_EMPTY);
  assign bus.o_ready    = (state_q != ST_TWO);
  assign bus.o_ext      = main_ext_q;
  assign bus.o_mode_err = main_err_q;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: directed mode, stall, flush and
// reset cases followed by a random soak, all scored against a queue model.
module tb_imm_extend_stage;

  localparam int NBITS     = 16;
  localparam int EXTBITS   = 32;
  localparam int SHAMTBITS = 5;

  logic clk;
  logic rst;
  logic flush;

  int total;
  int bad;
  int n_acc;
  int n_out;

  logic [EXTBITS:0] sb[$];

  imm_extend_stage_if #(.NBITS(NBITS), .EXTBITS(EXTBITS)) bus ();

  imm_extend_stage #(
    .NBITS    (NBITS),
    .EXTBITS  (EXTBITS),
    .SHAMTBITS(SHAMTBITS)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .i_flush(flush),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: value arithmetic on the immediate; returns {err, ext}.
  function automatic logic [EXTBITS:0] ref_model(input logic [NBITS-1:0] imm, input logic [2:0] mode);
    longint modx;
    longint sv;
    longint r;
    logic [63:0] rb;
    modx = longint'(1) << EXTBITS;
    sv = (longint'(imm) >= (longint'(1) << (NBITS-1))) ? longint'(imm) - (longint'(1) << NBITS)
                                                        : longint'(imm);
    case (mode)
      3'd0: r = sv;
      3'd1: r = longint'(imm);
      3'd2: r = longint'(imm) * (longint'(1) << (EXTBITS-NBITS));
      3'd3: r = sv * 4;
      3'd4: r = longint'(imm) % (longint'(1) << SHAMTBITS);
      default: return {1'b1, {EXTBITS{1'b0}}};
    endcase
    r = r % modx;
    if (r < 0) r = r + modx;
    rb = r;
    return {1'b0, rb[EXTBITS-1:0]};
  endfunction

  // One clock cycle: drive inputs after the falling edge, score the transfers
  // that the coming rising edge will perform.
  task automatic drive_cycle(input logic v, input logic [NBITS-1:0] imm, input logic [2:0] mode,
                             input logic rdy, input logic fl, input logic rs);
    logic [EXTBITS:0] e;
    @(negedge clk);
    bus.i_valid = v;
    bus.i_imm   = imm;
    bus.i_mode  = mode;
    bus.i_ready = rdy;
    flush       = fl;
    rst         = rs;
    #1;
    if (rs || fl) begin
      sb.delete();
    end else begin
      if (bus.o_valid && rdy) begin
        n_out++;
        $display("xfer %0d ext=%08h err=%0b", n_out, bus.o_ext, bus.o_mode_err);
        if (sb.size() == 0) begin
          check_eq("sb_spurious", 64'(bus.o_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("sb_ext", 64'(bus.o_ext), 64'(e[EXTBITS-1:0]));
          check_eq("sb_err", 64'(bus.o_mode_err), 64'(e[EXTBITS]));
        end
      end
      if (v && bus.o_ready) begin
        sb.push_back(ref_model(imm, mode));
        n_acc++;
      end
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [EXTBITS-1:0] ext, input logic err);
    check_eq({tag, "_valid"}, 64'(bus.o_valid), 64'(v));
    check_eq({tag, "_ext"}, 64'(bus.o_ext), 64'(ext));
    check_eq({tag, "_err"}, 64'(bus.o_mode_err), 64'(err));
  endtask

  logic [NBITS-1:0]   t_imm[5]  = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h07C3};
  logic [EXTBITS-1:0] t_exp[5]  = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC, 32'h00000003};
  string              t_name[5] = '{"sign", "zero", "upper", "branch", "shamt"};

  initial begin
    int cyc;
    total = 0; bad = 0; n_acc = 0; n_out = 0;
    bus.i_valid = 1'b0; bus.i_imm = '0; bus.i_mode = '0; bus.i_ready = 1'b0;
    flush = 1'b0; rst = 1'b1;

    drive_cycle(0, 0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 1, 0, 0);
    expect_out("reset", 0, 0, 0);
    check_eq("reset_ready", 64'(bus.o_ready), 64'd1);

    // Each mode, one cycle latency with downstream ready.
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1, t_imm[i], 3'(i), 1, 0, 0);
      drive_cycle(0, 0, 0, 1, 0, 0);
      expect_out(t_name[i], 1, t_exp[i], 0);
    end
    drive_cycle(0, 0, 0, 1, 0, 0);
    check_eq("idle_valid", 64'(bus.o_valid), 64'd0);

    // Illegal mode, then a legal beat right behind it.
    drive_cycle(1, 16'hABCD, 3'd6, 1, 0, 0);
    drive_cycle(1, 16'h0005, 3'd0, 1, 0, 0);
    expect_out("illegal", 1, 0, 1);
    drive_cycle(0, 0, 0, 1, 0, 0);
    expect_out("after_illegal", 1, 32'h5, 0);

    // Backpressure: two absorbed, third waits.
    drive_cycle(1, 16'h0001, 3'd0, 0, 0, 0);
    drive_cycle(1, 16'h0002, 3'd0, 0, 0, 0);
    expect_out("bp_first", 1, 32'h1, 0);
    check_eq("bp_ready_one", 64'(bus.o_ready), 64'd1);
    drive_cycle(1, 16'h0003, 3'd0, 0, 0, 0);
    check_eq("bp_full", 64'(bus.o_ready), 64'd0);
    drive_cycle(1, 16'h0003, 3'd0, 1, 0, 0);
    check_eq("bp_hold_ready", 64'(bus.o_ready), 64'd0);
    check_eq("bp_out1", 64'(bus.o_ext), 64'h1);
    drive_cycle(1, 16'h0003, 3'd0, 1, 0, 0);
    check_eq("bp_reassert", 64'(bus.o_ready), 64'd1);
    check_eq("bp_out2", 64'(bus.o_ext), 64'h2);
    drive_cycle(0, 0, 0, 1, 0, 0);
    expect_out("bp_out3", 1, 32'h3, 0);
    drive_cycle(0, 0, 0, 1, 0, 0);
    check_eq("bp_drained", 64'(bus.o_valid), 64'd0);

    // Flush while full, with a beat offered the same cycle.
    drive_cycle(1, 16'h1111, 3'd0, 0, 0, 0);
    drive_cycle(1, 16'h2222, 3'd0, 0, 0, 0);
    drive_cycle(1, 16'h5555, 3'd0, 0, 1, 0);
    drive_cycle(0, 0, 0, 1, 0, 0);
    expect_out("flush", 0, 0, 0);
    check_eq("flush_ready", 64'(bus.o_ready), 64'd1);
    drive_cycle(0, 0, 0, 1, 0, 0);
    check_eq("flush_no_5555", 64'(bus.o_valid), 64'd0);

    // Reset in the middle of traffic.
    for (int i = 0; i < 6; i++)
      drive_cycle(1, 16'($urandom), 3'($urandom_range(0, 4)), 1, 0, 0);
    drive_cycle(1, 16'h7777, 3'd0, 1, 0, 1);
    drive_cycle(1, 16'h0042, 3'd0, 1, 0, 0);
    expect_out("rst_mid", 0, 0, 0);
    check_eq("rst_mid_ready", 64'(bus.o_ready), 64'd1);
    drive_cycle(0, 0, 0, 1, 0, 0);
    expect_out("rst_resume", 1, 32'h42, 0);

    // Random soak.
    n_acc = 0;
    cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      drive_cycle($urandom_range(0, 99) < 70, 16'($urandom), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 99) < 60, 0, 0);
      cyc++;
    end
    check_eq("soak_beats", 64'(n_acc), 64'd10000);
    cyc = 0;
    while (sb.size() > 0 && cyc < 100) begin
      drive_cycle(0, 0, 0, 1, 0, 0);
      cyc++;
    end
    check_eq("soak_drain", 64'(sb.size()), 64'd0);
    drive_cycle(0, 0, 0, 1, 0, 0);
    check_eq("soak_idle", 64'(bus.o_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
